// File: rtl/l1_mux_pkg.sv
// Shared definitions for the L1 lane mux / arbiter / demux blocks.
// Holds the lane payload width, the lane count, the 2-bit lane index
// type, the 4-bit lane mask type and a modulo-4 lane increment helper.
package l1_mux_pkg;

    localparam int DATA_W  = 8;
    localparam int N_LANES = 4;

    typedef logic [1:0] lane_idx_t;
    typedef logic [3:0] lane_mask_t;

    // Next lane in round-robin order; the 2-bit width gives the wrap 3 -> 0.
    function automatic lane_idx_t lane_inc(input lane_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin picker that selects up to two lanes.
// Ports:
//   elig  in  4 : per-lane eligibility
//   ptr   in  2 : lane that is scanned first
//   gnt_a out 4 : one-hot, first eligible lane in scan order
//   gnt_b out 4 : one-hot, second eligible lane in scan order
//   idx_a out 2 : index of gnt_a
//   idx_b out 2 : index of gnt_b
//   cnt   out 2 : number of grants (0..2)
module rr_pick2
    import l1_mux_pkg::*;
(
    input  logic [3:0] elig,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_a,
    output logic [3:0] gnt_b,
    output logic [1:0] idx_a,
    output logic [1:0] idx_b,
    output logic [1:0] cnt
);

    lane_idx_t lane_s;
    logic      found_a_s;
    logic      found_b_s;

    // Scan ptr, ptr+1, ptr+2, ptr+3 and take the first two eligible lanes.
    always_comb begin
        lane_s    = 2'd0;
        found_a_s = 1'b0;
        found_b_s = 1'b0;
        idx_a     = 2'd0;
        idx_b     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            lane_s = ptr + 2'(k);
            if (elig[lane_s] && !found_a_s) begin
                found_a_s = 1'b1;
                idx_a     = lane_s;
            end else if (elig[lane_s] && !found_b_s) begin
                found_b_s = 1'b1;
                idx_b     = lane_s;
            end else begin
                found_b_s = found_b_s;
            end
        end
    end

    // Expand indices into one-hot grants and a grant count.
    always_comb begin
        if (found_a_s) begin
            gnt_a = 4'b0001 << idx_a;
        end else begin
            gnt_a = 4'b0000;
        end
        if (found_b_s) begin
            gnt_b = 4'b0001 << idx_b;
            cnt   = 2'd2;
        end else begin
            gnt_b = 4'b0000;
            cnt   = found_a_s ? 2'd1 : 2'd0;
        end
    end

endmodule

// File: rtl/l1_lane_arbiter.sv
// Round-robin arbiter sharing two registered output slots among four
// input lanes with valid/ready handshakes and a run-time lane enable mask.
// Ports:
//   clk_f, reset            : clock, synchronous active-high reset
//   data_0..3 / valid_0..3  : input lane payloads and valids
//   ready_0..3              : combinational per-lane grant
//   lane_en                 : lane enable mask
//   out_ready               : downstream accepts the output slots
//   data_00/valid_00        : registered slot 0 (first grant)
//   data_11/valid_11        : registered slot 1 (second grant)
module l1_lane_arbiter #(
    parameter int DATA_W  = 8,
    parameter int N_LANES = 4
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    input  logic              valid_3,
    output logic              ready_0,
    output logic              ready_1,
    output logic              ready_2,
    output logic              ready_3,
    input  logic [3:0]        lane_en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_00,
    output logic [DATA_W-1:0] data_11,
    output logic              valid_00,
    output logic              valid_11
);
    import l1_mux_pkg::lane_idx_t;
    import l1_mux_pkg::lane_mask_t;
    import l1_mux_pkg::lane_inc;

    logic [DATA_W-1:0]  lane_data_s [4];
    lane_mask_t         elig_s;
    logic [3:0]         gnt_a_s;
    logic [3:0]         gnt_b_s;
    lane_idx_t          idx_a_s;
    lane_idx_t          idx_b_s;
    logic [1:0]         cnt_s;
    logic [N_LANES-1:0] ready_s;

    lane_idx_t          ptr_r;
    lane_idx_t          ptr_nxt_s;
    logic [DATA_W-1:0]  data_00_r;
    logic [DATA_W-1:0]  data_11_r;
    logic               valid_00_r;
    logic               valid_11_r;
    logic [DATA_W-1:0]  data_00_nxt_s;
    logic [DATA_W-1:0]  data_11_nxt_s;
    logic               valid_00_nxt_s;
    logic               valid_11_nxt_s;

    assign lane_data_s[0] = data_0;
    assign lane_data_s[1] = data_1;
    assign lane_data_s[2] = data_2;
    assign lane_data_s[3] = data_3;

    // Eligibility is forced empty while stalled or in reset, so no grants issue.
    always_comb begin
        if (!reset && out_ready) begin
            elig_s = {valid_3, valid_2, valid_1, valid_0} & lane_en;
        end else begin
            elig_s = 4'b0000;
        end
    end

    rr_pick2 u_pick (
        .elig  (elig_s),
        .ptr   (ptr_r),
        .gnt_a (gnt_a_s),
        .gnt_b (gnt_b_s),
        .idx_a (idx_a_s),
        .idx_b (idx_b_s),
        .cnt   (cnt_s)
    );

    assign ready_s  = gnt_a_s | gnt_b_s;
    assign ready_0  = ready_s[0];
    assign ready_1  = ready_s[1];
    assign ready_2  = ready_s[2];
    assign ready_3  = ready_s[3];

    // Next slot contents and pointer; a lone grant always lands in slot 0.
    always_comb begin
        data_00_nxt_s  = {DATA_W{1'b0}};
        data_11_nxt_s  = {DATA_W{1'b0}};
        valid_00_nxt_s = 1'b0;
        valid_11_nxt_s = 1'b0;
        ptr_nxt_s      = ptr_r;
        case (cnt_s)
            2'd1: begin
                data_00_nxt_s  = lane_data_s[idx_a_s];
                valid_00_nxt_s = 1'b1;
                ptr_nxt_s      = lane_inc(idx_a_s);
            end
            2'd2: begin
                data_00_nxt_s  = lane_data_s[idx_a_s];
                valid_00_nxt_s = 1'b1;
                data_11_nxt_s  = lane_data_s[idx_b_s];
                valid_11_nxt_s = 1'b1;
                ptr_nxt_s      = lane_inc(idx_b_s);
            end
            default: begin
                ptr_nxt_s = ptr_r;
            end
        endcase
    end

    // Output slots and pointer load only when downstream accepts; else hold.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            data_00_r  <= {DATA_W{1'b0}};
            data_11_r  <= {DATA_W{1'b0}};
            valid_00_r <= 1'b0;
            valid_11_r <= 1'b0;
            ptr_r      <= 2'd0;
        end else if (out_ready) begin
            data_00_r  <= data_00_nxt_s;
            data_11_r  <= data_11_nxt_s;
            valid_00_r <= valid_00_nxt_s;
            valid_11_r <= valid_11_nxt_s;
            ptr_r      <= ptr_nxt_s;
        end
    end

    assign data_00  = data_00_r;
    assign data_11  = data_11_r;
    assign valid_00 = valid_00_r;
    assign valid_11 = valid_11_r;

endmodule

// File: tb/tb_l1_lane_arbiter.sv
// Self-checking bench for l1_lane_arbiter: directed scenarios with literal
// expectations, then a random soak against a scan-order reference model
// plus a byte-conservation check.
module tb_l1_lane_arbiter;

    logic       clk_f = 1'b0;
    logic       reset;
    logic [7:0] d [4];
    logic [3:0] v;
    logic [3:0] lane_en;
    logic       out_ready;
    logic [3:0] rdy;
    logic [7:0] data_00, data_11;
    logic       valid_00, valid_11;

    always #5 clk_f = ~clk_f;

    l1_lane_arbiter dut (
        .clk_f(clk_f), .reset(reset),
        .data_0(d[0]), .data_1(d[1]), .data_2(d[2]), .data_3(d[3]),
        .valid_0(v[0]), .valid_1(v[1]), .valid_2(v[2]), .valid_3(v[3]),
        .ready_0(rdy[0]), .ready_1(rdy[1]), .ready_2(rdy[2]), .ready_3(rdy[3]),
        .lane_en(lane_en), .out_ready(out_ready),
        .data_00(data_00), .data_11(data_11),
        .valid_00(valid_00), .valid_11(valid_11)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_ptr = 0;
    logic [7:0] m_d00 = 8'h00, m_d11 = 8'h00;
    logic       m_v00 = 1'b0,  m_v11 = 1'b0;
    logic [3:0] m_gnt = 4'b0000;

    // n-th (0-based) eligible lane walking from m_ptr, or -1 if none.
    function automatic int nth_elig(input int n);
        int c = 0;
        for (int k = 0; k < 4; k++) begin
            int l = (m_ptr + k) % 4;
            if (v[l] && lane_en[l]) begin
                if (c == n) return l;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r = 4'b0000;
        int a = nth_elig(0);
        int b = nth_elig(1);
        if (reset || !out_ready) return 4'b0000;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        return r;
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk_f) begin
        if (reset) begin
            m_ptr <= 0; m_d00 <= 8'h00; m_d11 <= 8'h00;
            m_v00 <= 1'b0; m_v11 <= 1'b0; m_gnt <= 4'b0000;
        end else if (out_ready) begin
            m_gnt <= exp_ready();
            m_v00 <= (nth_elig(0) >= 0);
            m_d00 <= (nth_elig(0) >= 0) ? d[nth_elig(0)] : 8'h00;
            m_v11 <= (nth_elig(1) >= 0);
            m_d11 <= (nth_elig(1) >= 0) ? d[nth_elig(1)] : 8'h00;
            if (nth_elig(1) >= 0)      m_ptr <= (nth_elig(1) + 1) % 4;
            else if (nth_elig(0) >= 0) m_ptr <= (nth_elig(0) + 1) % 4;
        end else begin
            m_gnt <= 4'b0000;
        end
    end

    // ---------------- compare process ----------------
    logic cmp_en   = 1'b0;
    logic tally_en = 1'b0;
    int   xfer_cnt = 0, cons_cnt = 0;
    int   xfer_sum = 0, cons_sum = 0;

    always @(negedge clk_f) begin
        if (cmp_en) begin
            chk("ready",    {28'd0, rdy},  {28'd0, exp_ready()});
            chk("two_max",  $countones(rdy) <= 2, 1);
            chk("data_00",  {24'd0, data_00}, {24'd0, m_d00});
            chk("data_11",  {24'd0, data_11}, {24'd0, m_d11});
            chk("valid_00", {31'd0, valid_00}, {31'd0, m_v00});
            chk("valid_11", {31'd0, valid_11}, {31'd0, m_v11});
            chk("ptr",      {30'd0, dut.ptr_r}, m_ptr);
        end
        if (tally_en && !reset && out_ready) begin
            for (int l = 0; l < 4; l++) begin
                if (v[l] && rdy[l]) begin
                    xfer_cnt = xfer_cnt + 1;
                    xfer_sum = xfer_sum + d[l];
                end
            end
            if (valid_00) begin cons_cnt = cons_cnt + 1; cons_sum = cons_sum + data_00; end
            if (valid_11) begin cons_cnt = cons_cnt + 1; cons_sum = cons_sum + data_11; end
        end
    end

    task automatic nxt();
        @(posedge clk_f);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk_f);
        #1;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1; lane_en = 4'hf; v = 4'b1111;
        d[0] = 8'hff; d[1] = 8'hee; d[2] = 8'hdd; d[3] = 8'hcc;

        // Reset: two cycles with all lanes valid.
        nxt();
        cmp_en = 1'b1;
        at_neg();
        chk("rst_ready", {28'd0, rdy}, 32'h0);
        chk("rst_v00", {31'd0, valid_00}, 32'h0);
        chk("rst_d00", {24'd0, data_00}, 32'h0);
        chk("rst_d11", {24'd0, data_11}, 32'h0);
        nxt();
        reset = 1'b0;

        // All lanes round-robin.
        at_neg();
        chk("rr_ready1", {28'd0, rdy}, 32'h3);
        nxt();
        chk("rr_d00", {24'd0, data_00}, 32'hff);
        chk("rr_d11", {24'd0, data_11}, 32'hee);
        chk("rr_ptr2", {30'd0, dut.ptr_r}, 32'd2);
        v[0] = 1'b0; v[1] = 1'b0;
        at_neg();
        chk("rr_ready2", {28'd0, rdy}, 32'hc);
        nxt();
        chk("rr_d00b", {24'd0, data_00}, 32'hdd);
        chk("rr_d11b", {24'd0, data_11}, 32'hcc);
        chk("rr_ptr0", {30'd0, dut.ptr_r}, 32'd0);

        // Single lane and wrap.
        v = 4'b0010; d[1] = 8'h77;
        at_neg();
        chk("one_ready", {28'd0, rdy}, 32'h2);
        nxt();
        chk("one_d00", {24'd0, data_00}, 32'h77);
        chk("one_v00", {31'd0, valid_00}, 32'h1);
        chk("one_v11", {31'd0, valid_11}, 32'h0);
        chk("one_ptr", {30'd0, dut.ptr_r}, 32'd2);
        v = 4'b1001; d[3] = 8'h33; d[0] = 8'h11;
        nxt();
        chk("wrap_d00", {24'd0, data_00}, 32'h33);
        chk("wrap_d11", {24'd0, data_11}, 32'h11);
        chk("wrap_ptr", {30'd0, dut.ptr_r}, 32'd1);

        // Backpressure.
        v = 4'b1111; d[2] = 8'hdd; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("bp_ready", {28'd0, rdy}, 32'h0);
            nxt();
            chk("bp_d00", {24'd0, data_00}, 32'h33);
            chk("bp_ptr", {30'd0, dut.ptr_r}, 32'd1);
        end
        out_ready = 1'b1;
        at_neg();
        chk("bp_resume", {28'd0, rdy}, 32'h6);
        nxt();
        chk("bp_res_d00", {24'd0, data_00}, 32'h77);
        chk("bp_res_d11", {24'd0, data_11}, 32'hdd);

        // Mask: only lanes 1 and 3 enabled.
        lane_en = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("mask_ready", {28'd0, rdy}, 32'ha);
            nxt();
        end

        // Drain, then random soak.
        v = 4'b0000; lane_en = 4'hf;
        nxt(); nxt();
        tally_en = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int l = 0; l < 4; l++) begin
                if (m_gnt[l] || !v[l]) begin
                    v[l] = ($urandom_range(0, 2) != 0);
                    d[l] = 8'($urandom_range(0, 255));
                end
            end
            if ($urandom_range(0, 7) == 0) lane_en = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            nxt();
        end
        v = 4'b0000; out_ready = 1'b1;
        nxt(); nxt(); nxt();
        tally_en = 1'b0;
        chk("cons_count", xfer_cnt, cons_cnt);
        chk("cons_sum", xfer_sum, cons_sum);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_lane_arbiter.md
# l1_lane_arbiter

Round-robin scheduler for the L1 lane multiplexer. It shares the two output lanes (slot 0 and slot 1) among four 8-bit input lanes. Each cycle it grants up to two valid input lanes with a valid/ready handshake and registers the granted bytes onto the output slots. A per-lane enable mask lets the lane set be configured at run time. It sits between the four-lane producers and the serializing output stage, in the `clk_f` domain.

## Interface
- `DATA_W`, default 8: lane payload width.
- `N_LANES`, default 4: number of input lanes. Fixed at 4; any other value is unsupported.

Ports:
- `clk_f` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_0`..`data_3` in `DATA_W`: input lane payloads.
- `valid_0`..`valid_3` in 1: lane i offers `data_i` this cycle.
- `ready_0`..`ready_3` out 1: lane i is granted this cycle. Combinational.
- `lane_en` in 4: lane enable mask, bit i for lane i. A lane with `lane_en[i]=0` is never granted.
- `out_ready` in 1: downstream accepts the output slots this cycle.
- `data_00`, `data_11` out `DATA_W`: registered output slot payloads.
- `valid_00`, `valid_11` out 1: registered output slot valids.

## Operation
- **Eligibility.** Lane i is eligible when `valid_i & lane_en[i]`.
- **Scan order.** A 2-bit pointer `ptr` sets the order: `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- **Grants.** Active only when `out_ready=1` and `reset=0`. The first eligible lane in scan order gets grant A; the second gets grant B. At most two grants per cycle.
- **Ready outputs.** `ready_i=1` exactly for lanes A and B. All `ready` are 0 when `out_ready=0` or `reset=1`.
- **Transfer.** A transfer occurs on lane i when `valid_i & ready_i`. Producers hold data and valid until they are granted.
- **Output load.** When `out_ready=1`:
  - `data_00`/`valid_00` take lane A's data and 1.
  - `data_11`/`valid_11` take lane B's data and 1.
  - A slot with no grant loads data 0 and valid 0.
  - A lone grant always goes to slot 0.
- **Output hold.** When `out_ready=0`, all outputs and `ptr` hold their values.
- **Pointer update.**
  - Two grants: `ptr <= B+1`.
  - One grant: `ptr <= A+1`.
  - No grants: `ptr` unchanged.
  - Wrap-around is mod 4 (lane 3 + 1 = lane 0).
- **Mask changes** take effect in the same cycle; they apply to combinational eligibility.

## Timing
- **Reset values.** `data_00=0`, `data_11=0`, `valid_00=0`, `valid_11=0`, `ptr=0`. All `ready` are 0 while `reset=1`.
- **Reset mid-operation.** Any in-flight output is discarded at the next edge. No lane transfers during the reset cycle.
- **Latency.** A byte granted in cycle n appears on its output slot in cycle n+1.
- **Throughput.** Two bytes per cycle.
- **Fairness.** With all four lanes continuously eligible, each lane is granted every second cycle and waits at most 1 idle cycle.
- **Simultaneous events.**
  - `out_ready` falling in the same cycle as valids: no grants, outputs hold.
  - A lane whose `lane_en` is cleared while it is valid is simply not granted. Its producer keeps holding.
- **Combinational path.** `ready_i` depends combinationally on `valid_*`, `lane_en`, `out_ready`, `reset` and `ptr`. Producers must not derive `valid` from `ready`.

## Structure
- **Shared package `l1_mux_pkg`:** `DATA_W`, `N_LANES`, the lane-index type (2-bit), and the `lane_mask` type (4-bit). The package is shared with the mux and demux blocks.
- **Sub-module `rr_pick2`:** combinational picker. Inputs are the 4-bit eligibility vector and `ptr`. Outputs are the grant-A and grant-B one-hot vectors, their indices, and a grant count (0..2).
- **Top level:** holds `ptr`, the output registers, and the data muxing.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with all lanes valid. Required: all outputs 0, all `ready` 0, and the first post-reset grant goes to lanes 0 and 1.
- **All lanes, round-robin.** Lanes 0..3 = `ff`, `ee`, `dd`, `cc`, all valid, `lane_en=f`, `out_ready=1`.
  - Cycle 1: `ready=0011`. Cycle 2: `00=ff`, `11=ee`.
  - After lanes 0/1 drop valid: lanes 2/3 are granted and output `dd`/`cc` next cycle; `ptr` returns to 0.
- **Single lane and wrap.** Only lane 1 valid with data `77`. Required: `00=77`, `valid_00=1`, `valid_11=0`, `ptr=2`. Then only lanes 3 and 0 valid: lane 3 goes to slot 0, lane 0 to slot 1, and `ptr=1`.
- **Backpressure.** Drive `out_ready=0` for 3 cycles with all lanes valid. Required: `ready=0000`, outputs and `ptr` frozen. On release, grants resume from the same `ptr`.
- **Mask.** Set `lane_en=1010` with all lanes valid. Required: only lanes 1 and 3 are ever granted, and lanes 0/2 hold valid indefinitely with `ready=0`.
- **Random soak.** Apply random valids, mask and `out_ready` for 500 cycles, checked against a scoreboard for:
  - no byte lost or duplicated;
  - at most two grants per cycle;
  - grant order matching the round-robin model.
